reg_write_decoder: RTL and testbench



---
 rtl/reg_write_decoder.sv | 125 ++++++++++++
 tb/tb_reg_write_decoder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/reg_write_decoder.sv
// Registered write-enable decoder for the register file.
// Turns a write-back index into a one-hot strobe and runs a zero-fill sweep after reset or on request.
module reg_write_decoder #(
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = 4,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_in,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear_req,
  output logic [15:0]       wen_onehot,
  output logic [DATA_W-1:0] wr_data_out,
  output logic              busy,
  output logic              clear_done,
  output logic              bad_sel
);

  typedef enum logic {
    CLEAR,
    IDLE
  } state_e;

  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_REGS - 1);
  localparam logic [SEL_W:0]   NUM_REGS_X = (SEL_W + 1)'(NUM_REGS);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [15:0]        wen_q, wen_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               bad_q, bad_d;
  logic               sel_ok;

  assign sel_ok = ({1'b0, wr_sel} < NUM_REGS_X);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      CLEAR: begin
        idx_d = idx_q + SEL_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  // busy_q is still high on the first IDLE edge after a sweep, which marks clear_done;
  // clear_done wins over bad_sel so the two pulses never coincide.
  always_comb begin
    wen_d  = '0;
    data_d = '0;
    busy_d = 1'b1;
    done_d = 1'b0;
    bad_d  = 1'b0;
    case (state_q)
      CLEAR: begin
        wen_d = 16'(1) << idx_q;
      end
      IDLE: begin
        busy_d = 1'b0;
        done_d = busy_q;
        if (clear_req) begin
          busy_d = 1'b1;
        end else if (wr_en_in && sel_ok) begin
          wen_d  = 16'(1) << wr_sel;
          data_d = wr_data;
        end else if (wr_en_in) begin
          bad_d = ~busy_q;
        end
      end
      default: begin
        busy_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wen_q  <= '0;
      data_q <= '0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
      bad_q  <= 1'b0;
    end else begin
      wen_q  <= wen_d;
      data_q <= data_d;
      busy_q <= busy_d;
      done_q <= done_d;
      bad_q  <= bad_d;
    end
  end

  assign wen_onehot  = wen_q;
  assign wr_data_out = data_q;
  assign busy        = busy_q;
  assign clear_done  = done_q;
  assign bad_sel     = bad_q;

endmodule

// File: tb/tb_reg_write_decoder.sv
// Table-driven scoreboard bench for reg_write_decoder, covering a 16-register
// and a 12-register instance driven by the same inputs.
module tb_reg_write_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset     = 1'b1;
  logic        wr_en_in  = 1'b0;
  logic [3:0]  wr_sel    = '0;
  logic [15:0] wr_data   = '0;
  logic        clear_req = 1'b0;

  logic [15:0] wen16, dout16, wen12, dout12;
  logic        busy16, done16, bad16, busy12, done12, bad12;

  reg_write_decoder #(.NUM_REGS(16), .SEL_W(4), .DATA_W(16)) dut16 (
    .clk(clk), .reset(reset), .wr_en_in(wr_en_in), .wr_sel(wr_sel),
    .wr_data(wr_data), .clear_req(clear_req), .wen_onehot(wen16),
    .wr_data_out(dout16), .busy(busy16), .clear_done(done16), .bad_sel(bad16)
  );

  reg_write_decoder #(.NUM_REGS(12), .SEL_W(4), .DATA_W(16)) dut12 (
    .clk(clk), .reset(reset), .wr_en_in(wr_en_in), .wr_sel(wr_sel),
    .wr_data(wr_data), .clear_req(clear_req), .wen_onehot(wen12),
    .wr_data_out(dout12), .busy(busy12), .clear_done(done12), .bad_sel(bad12)
  );

  typedef struct {
    string       name;
    bit          use12;
    logic        rst;
    logic        en;
    logic [3:0]  sel;
    logic [15:0] data;
    logic        clr;
    logic [15:0] expWen;
    logic [15:0] expData;
    logic        expBusy;
    logic        expDone;
    logic        expBad;
  } vec_t;

  typedef struct {
    string       name;
    bit          use12;
    logic [34:0] exp;
  } exp_t;

  vec_t vecs[$];
  exp_t scoreboard[$];
  int   checkCount = 0;
  int   passCount  = 0;

  function automatic void addVec(string name, bit use12, logic rst, logic en,
                                 logic [3:0] sel, logic [15:0] data, logic clr,
                                 logic [15:0] wen, logic [15:0] dout,
                                 logic b, logic d, logic bd);
    vec_t v;
    v.name = name; v.use12 = use12; v.rst = rst; v.en = en; v.sel = sel;
    v.data = data; v.clr = clr; v.expWen = wen; v.expData = dout;
    v.expBusy = b; v.expDone = d; v.expBad = bd;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput();
    exp_t        e;
    logic [34:0] act;
    checkCount++;
    if (scoreboard.size() == 0) begin
      $display("[TB] FAIL scoreboard_empty: got no expected entry, required one");
    end else begin
      e = scoreboard.pop_front();
      act = e.use12 ? {wen12, dout12, busy12, done12, bad12}
                    : {wen16, dout16, busy16, done16, bad16};
      if (act === e.exp) begin
        passCount++;
      end else begin
        $display("[TB] FAIL %s: got wen=%h data=%h busy=%b done=%b bad=%b, required wen=%h data=%h busy=%b done=%b bad=%b",
                 e.name, act[34:19], act[18:3], act[2], act[1], act[0],
                 e.exp[34:19], e.exp[18:3], e.exp[2], e.exp[1], e.exp[0]);
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clk);
    reset     = v.rst;
    wr_en_in  = v.en;
    wr_sel    = v.sel;
    wr_data   = v.data;
    clear_req = v.clr;
    e.name  = v.name;
    e.use12 = v.use12;
    e.exp   = {v.expWen, v.expData, v.expBusy, v.expDone, v.expBad};
    scoreboard.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic runTable();
    foreach (vecs[i]) applyStimulus(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t rv;

    // 16-register instance: reset, sweep, writes, clear priority, reset mid-sweep.
    addVec("reset0", 0, 1, 0, 4'd0, 16'h0, 0, 16'h0, 16'h0, 1, 0, 0);
    addVec("reset1", 0, 1, 0, 4'd0, 16'h0, 0, 16'h0, 16'h0, 1, 0, 0);
    for (int i = 0; i < 16; i++)
      addVec($sformatf("sweep_%0d", i), 0, 0, 0, 4'd0, 16'h0, 0, 16'(1) << i, 16'h0, 1, 0, 0);
    addVec("sweep_done", 0, 0, 0, 4'd0, 16'h0, 0, 16'h0, 16'h0, 0, 1, 0);
    addVec("idle_after_done", 0, 0, 0, 4'd0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 0);
    addVec("write_sel5", 0, 0, 1, 4'd5, 16'hBEEF, 0, 16'h0020, 16'hBEEF, 0, 0, 0);
    addVec("after_sel5", 0, 0, 0, 4'd5, 16'hBEEF, 0, 16'h0000, 16'h0000, 0, 0, 0);
    addVec("b2b_sel0", 0, 0, 1, 4'd0, 16'h1111, 0, 16'h0001, 16'h1111, 0, 0, 0);
    addVec("b2b_sel15", 0, 0, 1, 4'd15, 16'h2222, 0, 16'h8000, 16'h2222, 0, 0, 0);
    addVec("b2b_sel7", 0, 0, 1, 4'd7, 16'h3333, 0, 16'h0080, 16'h3333, 0, 0, 0);
    addVec("b2b_idle", 0, 0, 0, 4'd0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 0);
    addVec("clear_with_write", 0, 0, 1, 4'd3, 16'h9999, 1, 16'h0, 16'h0, 1, 0, 0);
    for (int i = 0; i < 16; i++)
      addVec($sformatf("clr_sweep_%0d", i), 0, 0, 1, 4'd3, 16'hFFFF, 0, 16'(1) << i, 16'h0, 1, 0, 0);
    addVec("clr_done_write", 0, 0, 1, 4'd2, 16'h4444, 0, 16'h0004, 16'h4444, 0, 1, 0);
    addVec("clr_idle", 0, 0, 0, 4'd0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 0);
    addVec("mid_clear", 0, 0, 0, 4'd0, 16'h0, 1, 16'h0, 16'h0, 1, 0, 0);
    for (int i = 0; i < 7; i++)
      addVec($sformatf("mid_sweep_%0d", i), 0, 0, 0, 4'd0, 16'h0, 0, 16'(1) << i, 16'h0, 1, 0, 0);
    addVec("mid_reset", 0, 1, 0, 4'd0, 16'h0, 0, 16'h0, 16'h0, 1, 0, 0);
    for (int i = 0; i < 16; i++)
      addVec($sformatf("restart_%0d", i), 0, 0, 0, 4'd0, 16'h0, 0, 16'(1) << i, 16'h0, 1, 0, 0);
    addVec("restart_done", 0, 0, 0, 4'd0, 16'h0, 0, 16'h0, 16'h0, 0, 1, 0);
    addVec("restart_idle", 0, 0, 0, 4'd0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 0);
    runTable();

    // Random back-to-back traffic on the idle 16-register instance.
    for (int i = 0; i < 40; i++) begin
      rv.name  = $sformatf("rand_%0d", i);
      rv.use12 = 0;
      rv.rst   = 0;
      rv.clr   = 0;
      rv.en    = 1'($urandom_range(0, 1));
      rv.sel   = 4'($urandom_range(0, 15));
      rv.data  = 16'($urandom);
      rv.expWen  = rv.en ? (16'(1) << rv.sel) : 16'h0;
      rv.expData = rv.en ? rv.data : 16'h0;
      rv.expBusy = 0;
      rv.expDone = 0;
      rv.expBad  = 0;
      applyStimulus(rv);
    end

    // 12-register instance: shortened sweep and out-of-range selects.
    addVec("r12_reset0", 1, 1, 0, 4'd0, 16'h0, 0, 16'h0, 16'h0, 1, 0, 0);
    addVec("r12_reset1", 1, 1, 0, 4'd0, 16'h0, 0, 16'h0, 16'h0, 1, 0, 0);
    for (int i = 0; i < 12; i++)
      addVec($sformatf("r12_sweep_%0d", i), 1, 0, 0, 4'd0, 16'h0, 0, 16'(1) << i, 16'h0, 1, 0, 0);
    addVec("r12_done", 1, 0, 0, 4'd0, 16'h0, 0, 16'h0, 16'h0, 0, 1, 0);
    addVec("r12_sel13", 1, 0, 1, 4'd13, 16'hAAAA, 0, 16'h0, 16'h0, 0, 0, 1);
    addVec("r12_sel12", 1, 0, 1, 4'd12, 16'hBBBB, 0, 16'h0, 16'h0, 0, 0, 1);
    addVec("r12_idle", 1, 0, 0, 4'd0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 0);
    addVec("r12_sel11", 1, 0, 1, 4'd11, 16'h5555, 0, 16'h0800, 16'h5555, 0, 0, 0);
    addVec("r12_idle2", 1, 0, 0, 4'd0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 0);
    runTable();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
